// File: rtl/iarray_tdm_mrmw_if.sv
// Port bundle for iarray_tdm_mrmw: per-port write/read requests, grants and
// read return data. The read-data vector is called dout because "do" is a
// reserved word in SystemVerilog.
interface iarray_tdm_mrmw_if #(
  parameter int NPORT   = 4,
  parameter int ADDRBIT = 11,
  parameter int WIDTH   = 8
);
  logic [NPORT-1:0]         we;
  logic [NPORT*ADDRBIT-1:0] wa;
  logic [NPORT*WIDTH-1:0]   di;
  logic [NPORT-1:0]         wrdy;
  logic [NPORT-1:0]         re;
  logic [NPORT*ADDRBIT-1:0] ra;
  logic [NPORT-1:0]         rrdy;
  logic [NPORT*WIDTH-1:0]   dout;
  logic [NPORT-1:0]         dvld;

  modport master (output we, wa, di, re, ra, input wrdy, rrdy, dout, dvld);
  modport slave  (input we, wa, di, re, ra, output wrdy, rrdy, dout, dvld);
endinterface

// File: rtl/iarray_tdm_mrmw.sv
// Time-multiplexed multi-read/multi-write memory: NPORT writers and NPORT
// readers share one single-write/single-read array. Each clock one writer and
// one reader are chosen by independent round-robin arbiters. After reset the
// array is filled with INITVAL, one word per clock, before any grant is given.
//
// state  | meaning
// S_INIT | sweeping INITVAL through addresses 0..DEPTH-1, grants held off
// S_RUN  | initialisation complete, arbitration active
module iarray_tdm_mrmw #(
  parameter int               ADDRBIT = 11,
  parameter int               DEPTH   = 2048,
  parameter int               WIDTH   = 8,
  parameter int               NPORT   = 4,
  parameter int               READLAT = 2,
  parameter                   RDMODE  = "WRFIRST",
  parameter logic [WIDTH-1:0] INITVAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  iarray_tdm_mrmw_if.slave    bus,
  input  logic                test,
  input  logic                mask,
  output logic                init_done
);

  localparam int PW       = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int MW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit WR_FIRST = (RDMODE == "WRFIRST");

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t             state;
  logic [ADDRBIT-1:0] init_addr;
  logic [WIDTH-1:0]   mem [DEPTH];

  logic [PW-1:0]      wptr, rptr, wsel, rsel;
  logic               wfire, rfire;
  logic [ADDRBIT-1:0] wr_addr, rd_addr, mem_waddr;
  logic [WIDTH-1:0]   wr_data, rd_data, mem_wdata;
  logic               wr_in_range, rd_in_range, mem_we;

  logic               p1_vld;
  logic [PW-1:0]      p1_port;
  logic [WIDTH-1:0]   p1_data;
  logic               last_vld;
  logic [PW-1:0]      last_port;
  logic [WIDTH-1:0]   last_data;

  // Port index i places after ptr, wrapping at NPORT.
  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] ptr, input int i);
    return PW'((int'(ptr) + i) % NPORT);
  endfunction

  // Round-robin pick: iterate from farthest to nearest so the nearest requester wins.
  always_comb begin
    wfire    = 1'b0;
    wsel     = '0;
    rfire    = 1'b0;
    rsel     = '0;
    bus.wrdy = '0;
    bus.rrdy = '0;
    if (init_done && !test) begin
      for (int i = NPORT - 1; i >= 0; i--) begin
        if (bus.we[rr_idx(wptr, i)]) begin
          wfire = 1'b1;
          wsel  = rr_idx(wptr, i);
        end
      end
      if (!mask) begin
        for (int i = NPORT - 1; i >= 0; i--) begin
          if (bus.re[rr_idx(rptr, i)]) begin
            rfire = 1'b1;
            rsel  = rr_idx(rptr, i);
          end
        end
      end
    end
    if (wfire) bus.wrdy[wsel] = 1'b1;
    if (rfire) bus.rrdy[rsel] = 1'b1;
  end

  assign wr_addr     = bus.wa[int'(wsel)*ADDRBIT +: ADDRBIT];
  assign wr_data     = bus.di[int'(wsel)*WIDTH +: WIDTH];
  assign rd_addr     = bus.ra[int'(rsel)*ADDRBIT +: ADDRBIT];
  assign wr_in_range = (int'(wr_addr) < DEPTH);
  assign rd_in_range = (int'(rd_addr) < DEPTH);

  // Read lookup; out-of-range addresses read as zero, WRFIRST forwards a colliding write.
  always_comb begin
    rd_data = '0;
    if (rd_in_range) begin
      rd_data = mem[rd_addr[MW-1:0]];
      if (WR_FIRST && wfire && (wr_addr == rd_addr)) rd_data = wr_data;
    end
  end

  // Single array write port shared by the init sweep and granted writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (!rst) begin
      if (state == S_INIT) begin
        mem_we    = 1'b1;
        mem_waddr = init_addr;
        mem_wdata = INITVAL;
      end else begin
        mem_we = wfire && wr_in_range;
      end
    end
  end

  // Array storage, no reset: contents are defined by the init sweep.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr[MW-1:0]] <= mem_wdata;
  end

  // Init sequencer; init_done rises together with the final sweep write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_INIT;
      init_addr <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          if (init_addr == ADDRBIT'(DEPTH - 1)) begin
            state     <= S_RUN;
            init_done <= 1'b1;
          end else begin
            init_addr <= init_addr + 1'b1;
          end
        end
        S_RUN:   state <= S_RUN;
        default: state <= S_INIT;
      endcase
    end
  end

  // Arbitration pointers move past the granted port, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wfire) wptr <= rr_idx(wsel, 1);
      if (rfire) rptr <= rr_idx(rsel, 1);
    end
  end

  // First read pipeline stage, only observed when READLAT is 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_vld  <= 1'b0;
      p1_port <= '0;
      p1_data <= '0;
    end else begin
      p1_vld  <= rfire;
      p1_port <= rsel;
      p1_data <= rd_data;
    end
  end

  assign last_vld  = (READLAT == 1) ? rfire   : p1_vld;
  assign last_port = (READLAT == 1) ? rsel    : p1_port;
  assign last_data = (READLAT == 1) ? rd_data : p1_data;

  // Return stage: one-cycle dvld pulse, dout slice holds its last delivery.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.dout <= '0;
      bus.dvld <= '0;
    end else begin
      bus.dvld <= '0;
      if (last_vld) begin
        bus.dvld[last_port]                       <= 1'b1;
        bus.dout[int'(last_port)*WIDTH +: WIDTH] <= last_data;
      end
    end
  end

endmodule

// File: tb/tb_iarray_tdm_mrmw.sv
// Bench for iarray_tdm_mrmw. Two instances share clock, reset and stimulus:
//   A: DEPTH=16, READLAT=2, WRFIRST, INITVAL=0x3C
//   B: DEPTH=12, READLAT=1, RDFIRST, INITVAL=0x00 (addresses 12..15 out of range)
// A word-array model with a queue of pending read returns predicts every
// output each cycle.
module tb_iarray_tdm_mrmw;
  localparam int NP = 4;
  localparam int AB = 4;
  localparam int W  = 8;

  logic clk = 1'b0;
  logic rst;
  logic test, mask;
  logic done_a, done_b;

  always #5 clk = ~clk;

  iarray_tdm_mrmw_if #(.NPORT(NP), .ADDRBIT(AB), .WIDTH(W)) bus_a ();
  iarray_tdm_mrmw_if #(.NPORT(NP), .ADDRBIT(AB), .WIDTH(W)) bus_b ();

  iarray_tdm_mrmw #(.ADDRBIT(AB), .DEPTH(16), .WIDTH(W), .NPORT(NP), .READLAT(2),
                    .RDMODE("WRFIRST"), .INITVAL(8'h3C)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.slave), .test(test), .mask(mask), .init_done(done_a));

  iarray_tdm_mrmw #(.ADDRBIT(AB), .DEPTH(12), .WIDTH(W), .NPORT(NP), .READLAT(1),
                    .RDMODE("RDFIRST"), .INITVAL(8'h00)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.slave), .test(test), .mask(mask), .init_done(done_b));

  logic [NP-1:0]    we_v, re_v;
  logic [NP*AB-1:0] wa_v, ra_v;
  logic [NP*W-1:0]  di_v;

  int checks = 0;
  int errors = 0;

  int         m_depth [2] = '{16, 12};
  int         m_lat   [2] = '{2, 1};
  bit         m_wrf   [2] = '{1'b1, 1'b0};
  logic [7:0] m_init  [2] = '{8'h3C, 8'h00};

  logic [7:0]  m_mem  [2][16];
  int          m_wptr [2];
  int          m_rptr [2];
  int          m_icnt [2];
  logic [3:0]  m_dvld [2];
  logic [31:0] m_dout [2];
  int          gw [2];
  int          gr [2];

  typedef struct {
    int         k;
    int         due;
    int         port;
    logic [7:0] data;
  } rd_t;
  rd_t pend[$];
  int  edge_n = 0;

  function automatic int pick(input logic [3:0] req, input int ptr);
    for (int i = 0; i < NP; i++)
      if (req[(ptr + i) % NP]) return (ptr + i) % NP;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_wptr[k] = 0;
      m_rptr[k] = 0;
      m_icnt[k] = 0;
      m_dvld[k] = '0;
      m_dout[k] = '0;
    end
    pend.delete();
  endtask

  task automatic check_dut(input int k, input logic o_done, input logic [3:0] o_wrdy,
                           input logic [3:0] o_rrdy, input logic [3:0] o_dvld,
                           input logic [31:0] o_dout);
    bit         done;
    logic [3:0] ew, er;
    string      nm;
    nm   = (k == 0) ? "A" : "B";
    done = (m_icnt[k] >= m_depth[k]);
    gw[k] = (done && !test) ? pick(we_v, m_wptr[k]) : -1;
    gr[k] = (done && !test && !mask) ? pick(re_v, m_rptr[k]) : -1;
    ew = (gw[k] >= 0) ? 4'(1 << gw[k]) : 4'd0;
    er = (gr[k] >= 0) ? 4'(1 << gr[k]) : 4'd0;
    chk($sformatf("%s.init_done@%0d", nm, edge_n), 64'(o_done), 64'(done));
    chk($sformatf("%s.wrdy@%0d", nm, edge_n), 64'(o_wrdy), 64'(ew));
    chk($sformatf("%s.rrdy@%0d", nm, edge_n), 64'(o_rrdy), 64'(er));
    chk($sformatf("%s.dvld@%0d", nm, edge_n), 64'(o_dvld), 64'(m_dvld[k]));
    chk($sformatf("%s.do@%0d", nm, edge_n), 64'(o_dout), 64'(m_dout[k]));
  endtask

  // One clock: drive at the falling edge, check, then advance the model at the rising edge.
  task automatic step();
    int         a, wa_g;
    logic [7:0] d;
    rd_t        keep[$];
    bus_a.we = we_v; bus_a.wa = wa_v; bus_a.di = di_v; bus_a.re = re_v; bus_a.ra = ra_v;
    bus_b.we = we_v; bus_b.wa = wa_v; bus_b.di = di_v; bus_b.re = re_v; bus_b.ra = ra_v;
    if (rst) model_reset();
    #1;
    check_dut(0, done_a, bus_a.wrdy, bus_a.rrdy, bus_a.dvld, bus_a.dout);
    check_dut(1, done_b, bus_b.wrdy, bus_b.rrdy, bus_b.dvld, bus_b.dout);
    @(posedge clk);
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        if (gr[k] >= 0) begin
          a = int'(ra_v[gr[k]*AB +: AB]);
          if (a >= m_depth[k]) d = 8'h00;
          else begin
            d = m_mem[k][a];
            if (m_wrf[k] && gw[k] >= 0) begin
              wa_g = int'(wa_v[gw[k]*AB +: AB]);
              if (wa_g == a) d = di_v[gw[k]*W +: W];
            end
          end
          pend.push_back('{k, edge_n + m_lat[k] - 1, gr[k], d});
          m_rptr[k] = (gr[k] + 1) % NP;
        end
        if (gw[k] >= 0) begin
          a = int'(wa_v[gw[k]*AB +: AB]);
          if (a < m_depth[k]) m_mem[k][a] = di_v[gw[k]*W +: W];
          m_wptr[k] = (gw[k] + 1) % NP;
        end
        if (m_icnt[k] < m_depth[k]) begin
          m_mem[k][m_icnt[k]] = m_init[k];
          m_icnt[k]++;
        end
        m_dvld[k] = '0;
      end
      foreach (pend[i]) begin
        if (pend[i].due == edge_n) begin
          m_dvld[pend[i].k][pend[i].port]        = 1'b1;
          m_dout[pend[i].k][pend[i].port*W +: W] = pend[i].data;
        end else begin
          keep.push_back(pend[i]);
        end
      end
      pend = keep;
    end
    edge_n++;
    @(negedge clk);
  endtask

  task automatic rand_req();
    we_v = 4'($urandom);
    re_v = 4'($urandom);
    wa_v = 16'($urandom);
    ra_v = 16'($urandom);
    di_v = $urandom;
  endtask

  task automatic idle();
    we_v = '0;
    re_v = '0;
  endtask

  initial begin
    rst = 1'b1; test = 1'b0; mask = 1'b0;
    we_v = '0; re_v = '0; wa_v = '0; ra_v = '0; di_v = '0;
    @(negedge clk);
    repeat (3) step();

    // Initialisation under random requests: no grants until each array is swept.
    rst = 1'b0;
    repeat (12) begin rand_req(); step(); end
    idle();
    repeat (6) step();

    // Every port reads every address; all ports requesting rotates the grant.
    for (int c = 0; c < 64; c++) begin
      re_v = 4'hF;
      for (int p = 0; p < NP; p++) ra_v[p*AB +: AB] = 4'(c / 4);
      step();
    end
    idle();
    repeat (3) step();

    // Same-cycle write 0xA5 and read of address 5.
    we_v = 4'b0001; wa_v = '0; wa_v[3:0] = 4'd5; di_v = '0; di_v[7:0] = 8'hA5;
    re_v = 4'b0010; ra_v = '0; ra_v[7:4] = 4'd5;
    step();
    idle();
    repeat (3) step();

    // All writers busy; grants rotate and each lands at its own address.
    we_v = 4'hF;
    for (int p = 0; p < NP; p++) wa_v[p*AB +: AB] = 4'(8 + p);
    repeat (12) begin di_v = $urandom; step(); end
    idle();
    for (int a = 8; a < 12; a++) begin
      re_v = 4'b0001; ra_v = '0; ra_v[3:0] = 4'(a);
      step();
    end
    idle();
    repeat (3) step();

    // Mask blocks reads; release resumes from the held pointer.
    mask = 1'b1; re_v = 4'hF; ra_v = 16'h3210;
    repeat (4) step();
    mask = 1'b0;
    repeat (4) step();
    idle();

    // Test freeze with a read already in flight.
    re_v = 4'b0100; ra_v = 16'h0300;
    step();
    test = 1'b1;
    repeat (4) begin rand_req(); step(); end
    test = 1'b0;

    // Random traffic with occasional mask/test.
    repeat (400) begin
      rand_req();
      mask = ($urandom_range(0, 9) == 0);
      test = ($urandom_range(0, 14) == 0);
      step();
    end
    mask = 1'b0; test = 1'b0;

    // Reset with a read in flight, then reset again mid-sweep at address 7.
    idle();
    re_v = 4'b0001; ra_v = 16'h0002;
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (7) begin rand_req(); step(); end
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (20) step();
    repeat (30) begin rand_req(); step(); end

    // Out-of-range write then read of address 13 (only B treats it as out of range).
    idle();
    we_v = 4'b0001; wa_v = 16'h000D; di_v = 32'h0000005A;
    step();
    idle();
    re_v = 4'b0001; ra_v = 16'h000D;
    step();
    idle();
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/iarray_tdm_mrmw.md
IARRAY_TDM_MRMW -- requirements
Module: iarray_tdm_mrmw

Interface
REQ-001 SHALL have parameter ADDRBIT, default 11: address width.
REQ-002 SHALL have parameter DEPTH, default 2048: number of words, at most 2^ADDRBIT.
REQ-003 SHALL have parameter WIDTH, default 8: data width.
REQ-004 SHALL have parameter NPORT, default 4: number of read ports and number of write ports, 1..8.
REQ-005 SHALL have parameter READLAT, default 2: read latency in clocks, 1 or 2.
REQ-006 SHALL have parameter RDMODE, default "WRFIRST": read/write collision policy, "WRFIRST" or "RDFIRST".
REQ-007 SHALL have parameter INITVAL, default 0: WIDTH-bit value written to every word after reset.
REQ-008 SHALL have port clk, input, 1 bit: single clock, all logic rising-edge.
REQ-009 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-010 SHALL have port we, input, NPORT bits: per-port write request.
REQ-011 SHALL have port wa, input, NPORT*ADDRBIT bits: write addresses, port p at slice p.
REQ-012 SHALL have port di, input, NPORT*WIDTH bits: write data, port p at slice p.
REQ-013 SHALL have port wrdy, output, NPORT bits: write grant.
REQ-014 SHALL have port re, input, NPORT bits: per-port read request.
REQ-015 SHALL have port ra, input, NPORT*ADDRBIT bits: read addresses.
REQ-016 SHALL have port rrdy, output, NPORT bits: read grant.
REQ-017 SHALL have port do, output, NPORT*WIDTH bits: read data, port p at slice p.
REQ-018 SHALL have port dvld, output, NPORT bits: read data valid pulse.
REQ-019 SHALL have port init_done, output, 1 bit: memory initialisation complete.
REQ-020 SHALL have port test, input, 1 bit: scan freeze; forces all grants to 0.
REQ-021 SHALL have port mask, input, 1 bit: forces all read grants to 0.

Function
REQ-022 SHALL grant at most one write port and at most one read port per clock.
REQ-023 SHALL compute wrdy/rrdy combinationally from we/re, the round-robin pointers, test, mask and init_done; a transfer occurs when request and grant are both high.
REQ-024 SHALL use independent write and read round-robin pointers: search starts at the pointer, the pointer moves to granted port+1 (mod NPORT) and holds when nothing is granted.
REQ-025 SHALL commit an accepted write to memory at the end of the grant cycle.
REQ-026 SHALL, for a read accepted in cycle T, drive the port-p do slice with the data and pulse dvld[p] high for one cycle at T+READLAT.
REQ-027 SHALL hold each do slice at its last delivered value between dvld pulses.
REQ-028 SHALL accept back-to-back reads from one port, one per clock, with no bubbles.
REQ-029 SHALL, for a same-cycle read and write to the same address, return the new data when RDMODE="WRFIRST" and the old data when RDMODE="RDFIRST".
REQ-030 SHALL return data written in cycle T to any read accepted in cycle T+1 or later.
REQ-031 SHALL discard writes with address >= DEPTH without side effect.
REQ-032 SHALL return all-zero data, with a normal dvld pulse, for reads with address >= DEPTH.
REQ-033 SHALL, after reset release, write INITVAL to addresses 0..DEPTH-1 at one per clock, taking DEPTH cycles.
REQ-034 SHALL hold init_done=0, wrdy=0 and rrdy=0 during initialisation.
REQ-035 SHALL set init_done=1 in the cycle after the write to address DEPTH-1 and keep it high until the next reset.
REQ-036 SHALL freeze the arbitration pointers and perform no memory write while test=1; read data already in flight still completes.

Reset
REQ-037 SHALL, while rst=1, drive do=0, dvld=0, init_done=0 and pointers=0, and drop in-flight reads.
REQ-038 SHALL, on rst asserted mid-initialisation or mid-operation, abort immediately and restart initialisation from address 0 after release.
REQ-039 SHALL leave memory contents undefined until init_done=1.

Verification
REQ-040 SHALL cover: DEPTH=16 init then reads from all ports of all addresses -> every read returns INITVAL, init_done rises exactly 16 cycles after rst release.
REQ-041 SHALL cover: all 4 ports hold we=1 continuously -> wrdy grants cycle 0,1,2,3,0,... and each write lands at its own address.
REQ-042 SHALL cover: write 0xA5 to addr 5 with a same-cycle read of addr 5 (old data 0x00) -> do=0xA5 under WRFIRST, 0x00 under RDFIRST, dvld at T+READLAT for both READLAT=1 and 2.
REQ-043 SHALL cover: mask=1 with re=4'b1111 -> rrdy=0 and no dvld pulse; mask released -> grants resume from the frozen pointer.
REQ-044 SHALL cover: rst pulse at init address 7, then a read in flight -> dvld suppressed, init restarts at 0, init_done delayed by a full DEPTH.
REQ-045 SHALL cover: DEPTH=12, ADDRBIT=4, write to addr 13 then read addr 13 -> write ignored and read returns 0 with a dvld pulse.
